// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_counter
// Purpose  : 1 Hz prescaler plus 24-hour hh:mm:ss BCD counter with manual
//            set, and a display copy that refreshes only at frame end.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_time_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       clear_sec,
    input  logic       v_Disp,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       sec_tick
);

    localparam int              c_PW  = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_TOP = c_PW'(TICK_DIV - 1);

    logic [c_PW-1:0] r_pre;
    logic [3:0]      r_h1, r_h0, r_m1, r_m0, r_s1, r_s0;
    logic [3:0]      w_h1, w_h0, w_m1, w_m0, w_s1, w_s0;
    logic            r_v_q;
    logic            r_sec_tick;
    logic            w_tick;
    logic            w_frame_end;
    logic            w_min_carry;
    logic            w_hour_carry;

    // clear_sec outranks the tick, so a cleared tick cycle never advances time.
    assign w_tick      = run && (r_pre == c_TOP) && !clear_sec;
    assign w_frame_end = r_v_q && !v_Disp;

    always_comb begin
        w_h1         = r_h1;
        w_h0         = r_h0;
        w_m1         = r_m1;
        w_m0         = r_m0;
        w_s1         = r_s1;
        w_s0         = r_s0;
        w_min_carry  = 1'b0;
        w_hour_carry = 1'b0;

        if (clear_sec) begin
            w_s1 = 4'd0;
            w_s0 = 4'd0;
        end

        if (!run) begin
            w_min_carry  = inc_min;
            w_hour_carry = inc_hour;
        end else if (w_tick) begin
            if (r_s0 == 4'd9) begin
                w_s0 = 4'd0;
                if (r_s1 == 4'd5) begin
                    w_s1        = 4'd0;
                    w_min_carry = 1'b1;
                end else begin
                    w_s1 = r_s1 + 4'd1;
                end
            end else begin
                w_s0 = r_s0 + 4'd1;
            end
        end

        if (w_min_carry) begin
            if (r_m0 == 4'd9) begin
                w_m0 = 4'd0;
                if (r_m1 == 4'd5) begin
                    w_m1 = 4'd0;
                    // In set mode minutes wrap without touching hours.
                    if (run) w_hour_carry = 1'b1;
                end else begin
                    w_m1 = r_m1 + 4'd1;
                end
            end else begin
                w_m0 = r_m0 + 4'd1;
            end
        end

        if (w_hour_carry) begin
            if (r_h1 == 4'd2 && r_h0 == 4'd3) begin
                w_h1 = 4'd0;
                w_h0 = 4'd0;
            end else if (r_h0 == 4'd9) begin
                w_h0 = 4'd0;
                w_h1 = r_h1 + 4'd1;
            end else begin
                w_h0 = r_h0 + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre      <= '0;
            r_h1       <= 4'd0;
            r_h0       <= 4'd0;
            r_m1       <= 4'd0;
            r_m0       <= 4'd0;
            r_s1       <= 4'd0;
            r_s0       <= 4'd0;
            r_v_q      <= 1'b0;
            r_sec_tick <= 1'b0;
            h1         <= 4'd0;
            h0         <= 4'd0;
            m1         <= 4'd0;
            m0         <= 4'd0;
            s1         <= 4'd0;
            s0         <= 4'd0;
        end else begin
            if (clear_sec)
                r_pre <= '0;
            else if (run)
                r_pre <= (r_pre == c_TOP) ? '0 : r_pre + c_PW'(1);

            r_h1       <= w_h1;
            r_h0       <= w_h0;
            r_m1       <= w_m1;
            r_m0       <= w_m0;
            r_s1       <= w_s1;
            r_s0       <= w_s0;
            r_v_q      <= v_Disp;
            r_sec_tick <= w_tick;

            // Load the post-update time so a same-edge change is not lost.
            if (w_frame_end) begin
                h1 <= w_h1;
                h0 <= w_h0;
                m1 <= w_m1;
                m0 <= w_m0;
                s1 <= w_s1;
                s0 <= w_s0;
            end
        end
    end

    assign sec_tick = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_time_counter
// Purpose  : Directed plus random stimulus against a seconds-of-day model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_time_counter;

    localparam int c_TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       inc_hour = 1'b0;
    logic       inc_min = 1'b0;
    logic       clear_sec = 1'b0;
    logic       v_Disp = 1'b0;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       sec_tick;

    int errors = 0;
    int checks = 0;

    // Reference state: time of day in seconds, prescaler count, shown time.
    int m_t    = 0;
    int m_pre  = 0;
    int m_disp = 0;
    bit m_vq   = 1'b0;
    bit m_st   = 1'b0;

    bcd_time_counter #(.TICK_DIV(c_TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .clear_sec(clear_sec),
        .v_Disp   (v_Disp),
        .h1       (h1),
        .h0       (h0),
        .m1       (m1),
        .m0       (m0),
        .s1       (s1),
        .s0       (s0),
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] expect_vec(input int t, input bit st);
        int hh, mm, ss;
        hh = t / 3600;
        mm = (t / 60) % 60;
        ss = t % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), st};
    endfunction

    task automatic cycle(input string tag, input bit rs, input bit rn,
                         input bit ih, input bit im, input bit cs, input bit vd);
        int  hh, mm, ss, nt;
        bit  tick;
        logic [24:0] obs, exp_v;
        reset = rs; run = rn; inc_hour = ih; inc_min = im;
        clear_sec = cs; v_Disp = vd;
        if (rs) begin
            m_t = 0; m_pre = 0; m_disp = 0; m_vq = 1'b0; m_st = 1'b0;
        end else begin
            tick = rn && (m_pre == c_TD - 1) && !cs;
            nt = m_t;
            if (cs) nt = nt - (nt % 60);
            if (!rn) begin
                hh = nt / 3600; mm = (nt / 60) % 60; ss = nt % 60;
                if (im) mm = (mm + 1) % 60;
                if (ih) hh = (hh + 1) % 24;
                nt = hh * 3600 + mm * 60 + ss;
            end else if (tick) begin
                nt = (nt + 1) % 86400;
            end
            if (cs) m_pre = 0;
            else if (rn) m_pre = (m_pre + 1) % c_TD;
            if (m_vq && !vd) m_disp = nt;
            m_vq = vd;
            m_st = tick;
            m_t  = nt;
        end
        @(posedge clk);
        #1;
        obs   = {h1, h0, m1, m0, s1, s0, sec_tick};
        exp_v = expect_vec(m_disp, m_st);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    // Run mode with the frame toggling so every few cycles latch the display.
    task automatic run_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i % 4) != 3);
    endtask

    task automatic set_time(input int hrs, input int mins);
        for (int i = 0; i < hrs; i++) cycle("set_h", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, i[0]);
        for (int i = 0; i < mins; i++) cycle("set_m", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, i[0]);
        cycle("set_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("set_lat", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset, then free run: ticks every 4 cycles, display frozen until frame end.
        cycle("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("reset2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle("freerun", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("first_fall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle("vd_low", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full-day rollover from 23:59:00.
        cycle("rst_roll", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(23, 59);
        run_cycles("to_235959", 59 * c_TD);
        run_cycles("wrap", 2 * c_TD);

        // Set-mode wrap behaviour starting at 23:59:30.
        cycle("rst_set", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(23, 59);
        run_cycles("to_235930", 30 * c_TD);
        cycle("min_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("min_wrap_l", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("hr_wrap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("hr_wrap_l", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(9, 9);
        cycle("both", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle("both_l", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("both_run", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle("both_run_l", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // clear_sec landing on the tick cycle at 12:34:59.
        cycle("rst_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(12, 34);
        run_cycles("to_123459", 59 * c_TD);
        for (int i = 0; i < c_TD - 1; i++) cycle("pre_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("clr_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("clr_notick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < c_TD; i++) cycle("after_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("after_clr_l", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-frame reset at 15:47:23.
        cycle("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(15, 47);
        run_cycles("to_154723", 23 * c_TD);
        cycle("frame_hi", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * c_TD; i++) cycle("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, i[0]);

        // Random mix of modes, pulses, frames and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            bit r_rn, r_ih, r_im, r_cs, r_rs, r_vd;
            r_rn = ($urandom_range(0, 9) < 6);
            r_ih = ($urandom_range(0, 3) == 0);
            r_im = ($urandom_range(0, 2) == 0);
            r_cs = ($urandom_range(0, 29) == 0);
            r_rs = ($urandom_range(0, 499) == 0);
            r_vd = ($urandom_range(0, 4) != 0);
            cycle("random", r_rs, r_rn, r_ih, r_im, r_cs, r_vd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
